// File: rtl/bch_sys_encoder.sv
// Bit-serial systematic BCH encoder for n = 63/255/1023 with per-frame generator.
// Message bits pass straight through; the LFSR remainder follows MSB first.
module bch_sys_encoder #(
   parameter int unsigned PAR_W = 40,
   parameter int unsigned GEN_W = 41
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_code,
   input  logic [GEN_W-1:0] i_gen,
   input  logic [5:0]       i_gen_deg,
   output logic             o_busy,
   input  logic             i_in_valid,
   input  logic             i_in_bit,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic             o_out_bit,
   output logic             o_out_last,
   input  logic             i_out_ready,
   output logic             o_done,
   output logic             o_err
);

   typedef enum logic [1:0] {StIdle, StMsg, StPar} state_e;

   state_e state_q, state_d;

   logic [5:0]       p_q, p_d;
   logic [PAR_W-1:0] mask_q, mask_d;
   logic [PAR_W-1:0] g_q, g_d;
   logic [PAR_W-1:0] r_q, r_d;
   logic [9:0]       k_q, k_d;
   logic [9:0]       msg_cnt_q, msg_cnt_d;
   logic [5:0]       par_cnt_q, par_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic             out_last_q, out_last_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [9:0]       n_in;
   logic [PAR_W-1:0] mask_in;
   logic [PAR_W-1:0] top;
   logic [PAR_W-1:0] shifted;
   logic             start_ok;
   logic             free;
   logic             accept;
   logic             msb;
   logic             fb;
   logic             msg_end;
   logic             par_end;

   // The leading generator coefficient is implicit in the degree.
   logic unused_gen_lead;
   assign unused_gen_lead = ^i_gen[GEN_W-1:PAR_W];

   always_comb begin
      case (i_code)
         2'd0:    n_in = 10'd63;
         2'd1:    n_in = 10'd255;
         2'd2:    n_in = 10'd1023;
         default: n_in = 10'd0;
      endcase
      start_ok = (i_code != 2'd3) && (i_gen_deg != 6'd0) &&
                 (32'(i_gen_deg) <= PAR_W) && ({4'b0, i_gen_deg} < n_in);
      mask_in  = (PAR_W'(1) << i_gen_deg) - PAR_W'(1);
      top      = mask_q & ~(mask_q >> 1);
      msb      = |(r_q & top);
      shifted  = (r_q << 1) & mask_q;
      fb       = i_in_bit ^ msb;
      free     = !out_valid_q || i_out_ready;
      accept   = (state_q == StMsg) && i_in_valid && free;
      msg_end  = (msg_cnt_q == k_q - 10'd1);
      par_end  = (par_cnt_q == p_q - 6'd1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_start && start_ok) state_d = StMsg;
         StMsg:   if (accept && msg_end) state_d = StPar;
         StPar:   if (free && par_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      p_d         = p_q;
      mask_d      = mask_q;
      g_d         = g_q;
      r_d         = r_q;
      k_d         = k_q;
      msg_cnt_d   = msg_cnt_q;
      par_cnt_d   = par_cnt_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_last_d  = out_last_q;
      done_d      = out_valid_q && out_last_q && i_out_ready;
      err_d       = (state_q == StIdle) && i_start && !start_ok;
      // A free slot drops the held bit unless something new is loaded below.
      if (free) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (i_start && start_ok) begin
               p_d       = i_gen_deg;
               mask_d    = mask_in;
               g_d       = i_gen[PAR_W-1:0] & mask_in;
               k_d       = n_in - {4'b0, i_gen_deg};
               r_d       = '0;
               msg_cnt_d = '0;
               par_cnt_d = '0;
            end
         end
         StMsg: begin
            if (accept) begin
               out_bit_d   = i_in_bit;
               out_valid_d = 1'b1;
               r_d         = shifted ^ (fb ? g_q : '0);
               msg_cnt_d   = msg_cnt_q + 10'd1;
               if (msg_end) par_cnt_d = '0;
            end
         end
         StPar: begin
            if (free) begin
               out_bit_d   = msb;
               out_valid_d = 1'b1;
               r_d         = shifted;
               par_cnt_d   = par_cnt_q + 6'd1;
               if (par_end) out_last_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         p_q         <= '0;
         mask_q      <= '0;
         g_q         <= '0;
         r_q         <= '0;
         k_q         <= '0;
         msg_cnt_q   <= '0;
         par_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         p_q         <= p_d;
         mask_q      <= mask_d;
         g_q         <= g_d;
         r_q         <= r_d;
         k_q         <= k_d;
         msg_cnt_q   <= msg_cnt_d;
         par_cnt_q   <= par_cnt_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      o_busy      = (state_q != StIdle);
      o_in_ready  = (state_q == StMsg) && free;
      o_out_valid = out_valid_q;
      o_out_bit   = out_bit_q;
      o_out_last  = out_last_q;
      o_done      = done_q;
      o_err       = err_q;
   end

endmodule

// File: tb/tb_bch_sys_encoder.sv
// Directed bench for bch_sys_encoder: hand-computed parities plus a long-division
// check that every codeword is a multiple of the generator.
module tb_bch_sys_encoder;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic [1:0]  i_code;
   logic [40:0] i_gen;
   logic [5:0]  i_gen_deg;
   logic        o_busy;
   logic        i_in_valid;
   logic        i_in_bit;
   logic        o_in_ready;
   logic        o_out_valid;
   logic        o_out_bit;
   logic        o_out_last;
   logic        i_out_ready;
   logic        o_done;
   logic        o_err;

   int n_cmp = 0;
   int n_err = 0;

   logic msg [0:1022];
   logic cw  [0:1022];
   int   cw_len;
   logic [63:0] frame_par;
   int   frame_first_acc;
   int   frame_done_it;

   bch_sys_encoder #(.PAR_W(40), .GEN_W(41)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_code      (i_code),
      .i_gen       (i_gen),
      .i_gen_deg   (i_gen_deg),
      .o_busy      (o_busy),
      .i_in_valid  (i_in_valid),
      .i_in_bit    (i_in_bit),
      .o_in_ready  (o_in_ready),
      .o_out_valid (o_out_valid),
      .o_out_bit   (o_out_bit),
      .o_out_last  (o_out_last),
      .i_out_ready (i_out_ready),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_msg();
      for (int i = 0; i < 1023; i++) msg[i] = 1'b0;
   endtask

   // Runs one frame cycle by cycle; inputs change on the falling edge.
   task automatic run_frame(input string tag, input logic [1:0] code, input logic [40:0] gen,
                            input int deg, input int n, input bit rnd, input bit mid_start);
      int k, mi, last_it, hold_err, last_err, err_seen, sys_err;
      bit stall, pv_bit, pv_last, fin;
      logic [63:0] rem;
      k = n - deg;
      mi = 0; cw_len = 0; last_it = -100; hold_err = 0; last_err = 0; err_seen = 0;
      frame_first_acc = -1; frame_done_it = -1;
      stall = 0; pv_bit = 0; pv_last = 0; fin = 0;
      for (int it = 0; it < 6000 && !fin; it++) begin
         @(negedge i_clk);
         if (o_err) err_seen++;
         if (stall && !(o_out_valid === 1'b1 && o_out_bit === pv_bit && o_out_last === pv_last))
            hold_err++;
         if (o_done) begin
            frame_done_it = it;
            fin = 1;
         end
         i_start     = (it == 0) || (mid_start && it == 30);
         i_code      = (it == 0) ? code : 2'd3;
         i_gen       = (it == 0) ? gen : 41'd0;
         i_gen_deg   = (it == 0) ? 6'(deg) : 6'd0;
         i_in_valid  = !fin && (mi < k) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         i_in_bit    = (mi < 1023) ? msg[mi] : 1'b0;
         i_out_ready = fin ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         #1;
         if (!fin) begin
            if (i_in_valid && o_in_ready) begin
               if (frame_first_acc < 0) frame_first_acc = it;
               mi++;
            end
            if (o_out_valid && i_out_ready) begin
               if (o_out_last !== (cw_len == n - 1)) last_err++;
               if (cw_len < 1023) cw[cw_len] = o_out_bit;
               else last_err++;
               cw_len++;
               if (o_out_last) last_it = it;
            end
            stall   = o_out_valid && !i_out_ready;
            pv_bit  = o_out_bit;
            pv_last = o_out_last;
         end
      end
      i_start = 1'b0;
      i_in_valid = 1'b0;
      check({tag, " done seen"}, 64'(frame_done_it >= 0), 64'd1);
      check({tag, " out len"}, 64'(cw_len), 64'(n));
      check({tag, " msg consumed"}, 64'(mi), 64'(k));
      check({tag, " last flag"}, 64'(last_err), 64'd0);
      check({tag, " done timing"}, 64'(frame_done_it - last_it), 64'd1);
      check({tag, " hold on stall"}, 64'(hold_err), 64'd0);
      check({tag, " no err"}, 64'(err_seen), 64'd0);
      check({tag, " busy low at done"}, {63'd0, o_busy}, 64'd0);
      sys_err = 0;
      for (int i = 0; i < k && i < cw_len; i++) if (cw[i] !== msg[i]) sys_err++;
      check({tag, " systematic"}, 64'(sys_err), 64'd0);
      rem = '0;
      for (int i = 0; i < n && i < cw_len; i++) begin
         rem = {rem[62:0], cw[i]};
         if (rem[deg]) rem = rem ^ 64'(gen);
      end
      check({tag, " divisible by g"}, rem, 64'd0);
      frame_par = '0;
      for (int i = k; i < n && i < cw_len; i++) frame_par = {frame_par[62:0], cw[i]};
   endtask

   initial begin
      logic [1:0] bad_code [0:2];
      logic [5:0] bad_deg [0:2];
      bad_code[0] = 2'd3; bad_deg[0] = 6'd6;
      bad_code[1] = 2'd0; bad_deg[1] = 6'd0;
      bad_code[2] = 2'd1; bad_deg[2] = 6'd41;

      i_rst_n = 1'b0; i_start = 1'b0; i_code = 2'd0; i_gen = '0; i_gen_deg = '0;
      i_in_valid = 1'b0; i_in_bit = 1'b0; i_out_ready = 1'b0;
      #1;
      check("reset outputs", {57'd0, o_busy, o_in_ready, o_out_valid, o_out_bit, o_out_last,
                              o_done, o_err}, 64'd0);
      #20;
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // x^6 + x + 1, all-zero message.
      clear_msg();
      run_frame("c0 zeros", 2'd0, 41'h43, 6, 63, 1'b0, 1'b0);
      check("c0 zeros parity", frame_par, 64'h00);

      // x^6 mod g = x + 1.
      clear_msg(); msg[56] = 1'b1;
      run_frame("c0 bit56", 2'd0, 41'h43, 6, 63, 1'b0, 1'b0);
      check("c0 bit56 parity", frame_par, 64'h03);

      // x^7 mod g = x^2 + x.
      clear_msg(); msg[55] = 1'b1;
      run_frame("c0 bit55", 2'd0, 41'h43, 6, 63, 1'b0, 1'b0);
      check("c0 bit55 parity", frame_par, 64'h06);

      clear_msg();
      for (int i = 0; i < 247; i++) msg[i] = 1'($urandom_range(0, 1));
      run_frame("c1 random", 2'd1, 41'h11D, 8, 255, 1'b1, 1'b1);

      clear_msg();
      for (int i = 0; i < 1013; i++) msg[i] = 1'($urandom_range(0, 1));
      run_frame("c2 stream", 2'd2, 41'h409, 10, 1023, 1'b0, 1'b0);
      check("c2 done latency", 64'(frame_done_it - frame_first_acc), 64'd1024);

      for (int v = 0; v < 3; v++) begin
         @(negedge i_clk);
         i_start = 1'b1; i_code = bad_code[v]; i_gen = 41'h43; i_gen_deg = bad_deg[v];
         i_out_ready = 1'b1;
         @(negedge i_clk);
         i_start = 1'b0;
         check($sformatf("bad start %0d err", v), {63'd0, o_err}, 64'd1);
         check($sformatf("bad start %0d busy", v), {63'd0, o_busy}, 64'd0);
         @(negedge i_clk);
         check($sformatf("bad start %0d err pulse", v), {63'd0, o_err}, 64'd0);
      end

      // Abort during the parity phase.
      @(negedge i_clk);
      i_start = 1'b1; i_code = 2'd0; i_gen = 41'h43; i_gen_deg = 6'd6;
      i_in_valid = 1'b0; i_in_bit = 1'b0; i_out_ready = 1'b1;
      for (int it = 1; it <= 60; it++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         i_in_valid = 1'b1;
      end
      @(negedge i_clk);
      i_in_valid = 1'b0;
      #1;
      check("mid par state", {61'd0, o_busy, o_in_ready, o_out_valid}, 64'b101);
      i_rst_n = 1'b0;
      #1;
      check("async reset outputs", {57'd0, o_busy, o_in_ready, o_out_valid, o_out_bit,
                                    o_out_last, o_done, o_err}, 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      clear_msg(); msg[56] = 1'b1;
      run_frame("post reset", 2'd0, 41'h43, 6, 63, 1'b0, 1'b0);
      check("post reset parity", frame_par, 64'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
